// File: rtl/seq_deserializer_if.sv
// Bus bundle for the serial-to-parallel deserializer: serial input side and
// the registered word/status outputs.
interface seq_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic                  ds;
  logic                  en;
  logic                  sync;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dvalid;
  logic                  match;
  logic [CNT_W-1:0]      bit_cnt;
  logic [7:0]            word_cnt;

  modport master (
    output ds, en, sync,
    input  dout, dvalid, match, bit_cnt, word_cnt
  );

  modport slave (
    input  ds, en, sync,
    output dout, dvalid, match, bit_cnt, word_cnt
  );
endinterface

// File: rtl/seq_deserializer.sv
// LSB-first serial deserializer with frame restart, per-word valid pulse and
// a registered pattern-match flag on each completed word.
module seq_deserializer #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(8'b00001110)
) (
  input  logic              clk,
  input  logic              clrn,
  seq_deserializer_if.slave bus
);
  localparam int             CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;
  logic                  match_q, match_d;
  logic [7:0]            word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] word_w;

  // The top bit never needs storing: it arrives on the edge that completes the word.
  assign word_w = {bus.ds, shift_q};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    dout_d     = dout_q;
    match_d    = match_q;
    word_cnt_d = word_cnt_q;
    dvalid_d   = 1'b0;

    if (bus.en) begin
      state_d = RECV;
      if (bus.sync) begin
        shift_d    = '0;
        shift_d[0] = bus.ds;
        bit_cnt_d  = CNT_W'(1);
      end else if (bit_cnt_q == LAST_BIT) begin
        dout_d     = word_w;
        match_d    = (word_w == PATTERN);
        word_cnt_d = word_cnt_q + 8'd1;
        dvalid_d   = 1'b1;
        bit_cnt_d  = '0;
        shift_d    = '0;
      end else begin
        shift_d[bit_cnt_q] = bus.ds;
        bit_cnt_d          = bit_cnt_q + CNT_W'(1);
      end
    end else if (bus.sync) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      match_q    <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      match_q    <= match_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dvalid   = dvalid_q;
  assign bus.match    = match_q;
  assign bus.bit_cnt  = bit_cnt_q;
  assign bus.word_cnt = word_cnt_q;
endmodule

// File: tb/tb_seq_deserializer.sv
// Directed and randomized checks of seq_deserializer against a bit-list
// reference model of the receive rules.
module tb_seq_deserializer;
  logic clk = 1'b0;
  logic clrn;

  always #5 clk = ~clk;

  seq_deserializer_if #(.DATA_WIDTH(8)) bus();

  seq_deserializer #(.DATA_WIDTH(8), .PATTERN(8'h0E)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int dvalid_seen = 0;

  // Reference model: the bits of the current frame in arrival order.
  bit         m_bits[$];
  logic [7:0] m_dout;
  logic [7:0] m_wcnt;
  logic       m_dvalid;
  logic       m_match;

  function automatic void modelReset();
    m_bits.delete();
    m_dout   = 8'h00;
    m_wcnt   = 8'h00;
    m_dvalid = 1'b0;
    m_match  = 1'b0;
  endfunction

  function automatic void modelStep(input logic ds, input logic en, input logic sync);
    int word;
    m_dvalid = 1'b0;
    if (en) begin
      if (sync) m_bits.delete();
      m_bits.push_back(ds);
      if (m_bits.size() == 8) begin
        word = 0;
        for (int i = 0; i < 8; i++) word += int'(m_bits[i]) * (1 << i);
        m_dout   = 8'(word);
        m_match  = (word == 14);
        m_wcnt   = 8'((int'(m_wcnt) + 1) % 256);
        m_dvalid = 1'b1;
        m_bits.delete();
      end
    end else if (sync) begin
      m_bits.delete();
    end
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".dout"},     32'(bus.dout),     32'(m_dout));
    checkOne({tag, ".dvalid"},   32'(bus.dvalid),   32'(m_dvalid));
    checkOne({tag, ".match"},    32'(bus.match),    32'(m_match));
    checkOne({tag, ".bit_cnt"},  32'(bus.bit_cnt),  32'(m_bits.size()));
    checkOne({tag, ".word_cnt"}, 32'(bus.word_cnt), 32'(m_wcnt));
  endtask

  // Drive at the falling edge, let one rising edge happen, check at the next falling edge.
  task automatic applyStimulus(input logic ds, input logic en, input logic sync, input string tag);
    bus.ds   = ds;
    bus.en   = en;
    bus.sync = sync;
    @(posedge clk);
    modelStep(ds, en, sync);
    @(negedge clk);
    if (bus.dvalid === 1'b1) dvalid_seen++;
    checkOutput(tag);
  endtask

  task automatic sendWord(input logic [7:0] w, input string tag);
    for (int i = 0; i < 8; i++) applyStimulus(w[i], 1'b1, 1'b0, tag);
  endtask

  task automatic pulseReset(input string tag);
    @(negedge clk);
    #2 clrn = 1'b0;
    modelReset();
    #1 checkOutput(tag);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    logic [7:0] w;
    bus.ds   = 1'b0;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    clrn     = 1'b0;
    modelReset();
    #3 checkOutput("reset");
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;

    sendWord(8'h0E, "w0E");
    checkOne("w0E.dout_const",  32'(bus.dout),     32'h0E);
    checkOne("w0E.match_const", 32'(bus.match),    32'h1);
    checkOne("w0E.wcnt_const",  32'(bus.word_cnt), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, "w0F_bit0");
    checkOne("w0F.dvalid_one_cycle", 32'(bus.dvalid), 32'h0);
    w = 8'h0F;
    for (int i = 1; i < 8; i++) applyStimulus(w[i], 1'b1, 1'b0, "w0F");
    checkOne("w0F.dout_const",  32'(bus.dout),  32'h0F);
    checkOne("w0F.match_const", 32'(bus.match), 32'h0);

    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (i == 4)
        for (int s = 0; s < 3; s++) applyStimulus(1'($urandom), 1'b0, 1'b0, "stall");
      applyStimulus(w[i], 1'b1, 1'b0, "wA5");
    end
    checkOne("wA5.dout_const", 32'(bus.dout), 32'hA5);

    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, "pre_sync");
    applyStimulus(1'b1, 1'b1, 1'b1, "sync_en");
    w = 8'h0F;
    for (int i = 1; i < 8; i++) applyStimulus(w[i], 1'b1, 1'b0, "post_sync");
    checkOne("sync_en.dout_const", 32'(bus.dout), 32'h0F);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, "pre_sync_idle");
    applyStimulus(1'b1, 1'b0, 1'b1, "sync_idle");
    sendWord(8'h5A, "after_sync_idle");

    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, "pre_sync_b7");
    applyStimulus(1'b0, 1'b1, 1'b1, "sync_b7");
    sendWord(8'hC3, "after_sync_b7");

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, "pre_reset");
    pulseReset("async_reset");
    sendWord(8'h3C, "w3C");
    checkOne("w3C.dout_const", 32'(bus.dout),     32'h3C);
    checkOne("w3C.wcnt_const", 32'(bus.word_cnt), 32'h1);

    pulseReset("reset_before_wrap");
    dvalid_seen = 0;
    for (int k = 0; k < 256; k++) sendWord(8'h00, "wrap");
    checkOne("wrap.dvalid_count", 32'(dvalid_seen),  32'd256);
    checkOne("wrap.word_cnt",     32'(bus.word_cnt), 32'h0);

    for (int k = 0; k < 600; k++)
      applyStimulus(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, "random");

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_deserializer.md
SEQ_DESERIALIZER -- requirements
Module: seq_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width and bits per frame.
REQ-002 SHALL have parameter PATTERN, default 8'b00001110, word value that asserts match.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ds  input  1  serial data bit; LSB of each word first.
REQ-006 SHALL have port en  input  1  bit-valid qualifier; ds sampled only when en=1.
REQ-007 SHALL have port sync  input  1  synchronous frame restart; discards any partial word.
REQ-008 SHALL have port dout  output  DATA_WIDTH  last complete received word, registered.
REQ-009 SHALL have port dvalid  output  1  one-cycle pulse marking a new dout.
REQ-010 SHALL have port match  output  1  registered flag, dout==PATTERN, updated with dout.
REQ-011 SHALL have port bit_cnt  output  3  index of the next bit to be captured (0..7).
REQ-012 SHALL have port word_cnt  output  8  count of completed words, modulo 256.

Function
REQ-013 SHALL implement FSM states IDLE and RECV; IDLE->RECV on first sampled bit (en=1), RECV->IDLE when sync=1 with en=0.
REQ-014 SHALL, on a rising edge with en=1, write ds into shift register position bit_cnt and increment bit_cnt.
REQ-015 SHALL, with en=0, hold bit_cnt, the shift register, dout, match and word_cnt unchanged (stall of any length).
REQ-016 SHALL, on the edge sampling bit index 7 (en=1, bit_cnt=7), load dout with {ds, shift[6:0]}, wrap bit_cnt to 0, and increment word_cnt.
REQ-017 SHALL assert dvalid for exactly the cycle following the edge of REQ-016 (latency: dout/dvalid/match valid one cycle after last bit sampled); dvalid=0 otherwise.
REQ-018 SHALL compute match from the word loaded into dout at the same edge; match holds until the next word completes.
REQ-019 SHALL leave dout, match and word_cnt unchanged while a word is partially received.
REQ-020 SHALL, on sync=1 with en=0, clear bit_cnt to 0 and the partial shift contents; dout, match, word_cnt retained.
REQ-021 SHALL, on sync=1 with en=1, discard the partial word and capture ds as bit 0 (bit_cnt becomes 1); state RECV.
REQ-022 SHALL, if sync=1 coincides with bit_cnt=7 and en=1, treat ds as bit 0 of a new frame; no word completes, no dvalid.
REQ-023 SHALL wrap word_cnt from 255 to 0 with no flag.
REQ-024 SHALL align to frame boundary from reset release: first sampled bit after clrn rises is bit 0.

Reset
REQ-025 SHALL, while clrn=0 regardless of clk, force: state IDLE, bit_cnt=0, shift register=0, dout=0, dvalid=0, match=0, word_cnt=0.
REQ-026 SHALL, on clrn asserted mid-word, abandon the partial word with no dvalid; first en=1 edge after release captures bit 0.

Verification
REQ-027 Reset then en=1 continuously, ds=0,1,1,1,0,0,0,0 -> one cycle after 8th edge dout=8'h0E, dvalid=1 for one cycle, match=1, word_cnt=1.
REQ-028 Next frame ds bits of 8'h0F (1,1,1,1,0,0,0,0) -> dout=8'h0F, match=0, word_cnt=2; dout stays 8'h0E during bits 0..7.
REQ-029 8'hA5 with en=0 for 3 cycles after bit 3 -> bit_cnt holds 4 during stall, dout=8'hA5 exactly 8 enabled edges after start, single dvalid.
REQ-030 Send 5 bits, pulse sync with en=1 and ds=1, then 7 bits of 8'h0E's upper bits -> dout=8'h0F... ; verify partial discarded: 8 bits total after sync form dout, no dvalid before.
REQ-031 clrn low after 4 bits of a word -> all outputs 0 immediately (asynchronous), next 8 bits 8'h3C -> dout=8'h3C, word_cnt=1.
REQ-032 256 consecutive words of 8'h00 -> word_cnt wraps to 0, 256 dvalid pulses, match=0 throughout.
